// File: rtl/dot_product_feeder.sv
// dot_product_feeder: packs a stream of (a,b) pairs into the eight accelerator
// lanes, zero-padding short frames, pulses acc_start, waits for a fresh done
// (with timeout) and returns the 64-bit result over a valid/ready handshake.
// Ports: clk, rst_n (async, active-low); s_valid/s_ready/s_a/s_b/s_last input
// stream; a0..a7, b0..b7 lanes, acc_start, acc_done, acc_result accelerator
// side; m_valid/m_ready/m_result/m_error result stream; busy (not in LOAD).
module dot_product_feeder #(
    parameter int LANES   = 8,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_a,
    input  logic signed [WIDTH-1:0] s_b,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] a0,
    output logic signed [WIDTH-1:0] a1,
    output logic signed [WIDTH-1:0] a2,
    output logic signed [WIDTH-1:0] a3,
    output logic signed [WIDTH-1:0] a4,
    output logic signed [WIDTH-1:0] a5,
    output logic signed [WIDTH-1:0] a6,
    output logic signed [WIDTH-1:0] a7,
    output logic signed [WIDTH-1:0] b0,
    output logic signed [WIDTH-1:0] b1,
    output logic signed [WIDTH-1:0] b2,
    output logic signed [WIDTH-1:0] b3,
    output logic signed [WIDTH-1:0] b4,
    output logic signed [WIDTH-1:0] b5,
    output logic signed [WIDTH-1:0] b6,
    output logic signed [WIDTH-1:0] b7,
    output logic                    acc_start,
    input  logic                    acc_done,
    input  logic signed [63:0]      acc_result,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [63:0]      m_result,
    output logic                    m_error,
    output logic                    busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_CLR,
        WAIT_DONE,
        OUTPUT
    } state_t;

    state_t                  state;
    logic [2:0]              idx;
    logic [CW-1:0]           tcnt;
    logic signed [WIDTH-1:0] la [LANES];
    logic signed [WIDTH-1:0] lb [LANES];
    logic                    take;
    logic                    tmo;
    logic                    frame_end;

    // s_ready is only ever high in LOAD, so it alone qualifies the handshake
    assign take      = s_valid & s_ready;
    assign tmo       = (tcnt == CW'(TIMEOUT - 1));
    assign frame_end = s_last | (idx == 3'd7);

    assign a0 = la[0];
    assign a1 = la[1];
    assign a2 = la[2];
    assign a3 = la[3];
    assign a4 = la[4];
    assign a5 = la[5];
    assign a6 = la[6];
    assign a7 = la[7];
    assign b0 = lb[0];
    assign b1 = lb[1];
    assign b2 = lb[2];
    assign b3 = lb[3];
    assign b4 = lb[4];
    assign b5 = lb[5];
    assign b6 = lb[6];
    assign b7 = lb[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            tcnt      <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            acc_start <= 1'b0;
            m_valid   <= 1'b0;
            m_result  <= '0;
            m_error   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                la[i] <= '0;
                lb[i] <= '0;
            end
        end else begin
            acc_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (take) begin
                        la[idx] <= s_a;
                        lb[idx] <= s_b;
                        if (frame_end) begin
                            idx       <= '0;
                            state     <= START;
                            acc_start <= 1'b1;
                            s_ready   <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // a done left high by the previous job must fall first
                    tcnt <= tcnt + CW'(1);
                    if (tmo) begin
                        m_result <= '0;
                        m_error  <= 1'b1;
                        m_valid  <= 1'b1;
                        state    <= OUTPUT;
                    end else if (!acc_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tcnt <= tcnt + CW'(1);
                    // done beats a coincident timeout
                    if (acc_done) begin
                        m_result <= acc_result;
                        m_error  <= 1'b0;
                        m_valid  <= 1'b1;
                        state    <= OUTPUT;
                    end else if (tmo) begin
                        m_result <= '0;
                        m_error  <= 1'b1;
                        m_valid  <= 1'b1;
                        state    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= LOAD;
                        // cleared lanes give zero padding for the next frame
                        for (int i = 0; i < LANES; i++) begin
                            la[i] <= '0;
                            lb[i] <= '0;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_feeder.sv
// tb_dot_product_feeder: directed table of frames against a small accelerator
// stub, plus hand sequences for back-pressure, timeout and async reset.
module tb_dot_product_feeder;

    typedef struct {
        int              n;
        bit              last;
        logic [7:0][31:0] a;
        logic [7:0][31:0] b;
        longint          exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_last;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic        acc_start;
    logic        acc_done;
    logic [63:0] acc_result;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_result;
    logic        m_error;
    logic        busy;

    logic [7:0][31:0] la_v;
    logic [7:0][31:0] lb_v;

    int   total = 0;
    int   bad = 0;
    bit   stuck;
    int   acnt;
    vec_t tbl [6];

    assign la_v = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign lb_v = {b7, b6, b5, b4, b3, b2, b1, b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dot_product_feeder #(
        .LANES  (8),
        .WIDTH  (32),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_last    (s_last),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .a5        (a5),
        .a6        (a6),
        .a7        (a7),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .b4        (b4),
        .b5        (b5),
        .b6        (b6),
        .b7        (b7),
        .acc_start (acc_start),
        .acc_done  (acc_done),
        .acc_result(acc_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_result  (m_result),
        .m_error   (m_error),
        .busy      (busy)
    );

    function automatic longint dot();
        longint s;
        s = 0;
        for (int i = 0; i < 8; i++)
            s += longint'($signed(la_v[i])) * longint'($signed(lb_v[i]));
        return s;
    endfunction

    // accelerator stub: done stays high until two cycles after a new start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_done   <= 1'b0;
            acc_result <= '0;
            acnt       <= 0;
        end else if (stuck) begin
            acc_done <= 1'b0;
            acnt     <= 0;
        end else if (acc_start) begin
            acnt <= 5;
        end else if (acnt > 0) begin
            acnt <= acnt - 1;
            if (acnt == 4) acc_done <= 1'b0;
            if (acnt == 1) begin
                acc_done   <= 1'b1;
                acc_result <= dot();
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input vec_t v, input bit gaps);
        int i;
        int guard;
        bit hs;
        i = 0;
        guard = 0;
        while (i < v.n && guard < 500) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_a     = v.a[i];
                s_b     = v.b[i];
                s_last  = v.last && (i == v.n - 1);
            end
            hs = s_valid && s_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs) i++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("frame_accepted", 64'(i), 64'(v.n));
        check("start_pulse", acc_start, 1);
    endtask

    task automatic wait_result(input longint exp, input bit experr,
                               input vec_t v, input int hold,
                               output int lat);
        logic [7:0][31:0] ea;
        logic [7:0][31:0] eb;
        logic [63:0] r;
        bit stable;
        for (int j = 0; j < 8; j++) begin
            ea[j] = (j < v.n) ? v.a[j] : 32'd0;
            eb[j] = (j < v.n) ? v.b[j] : 32'd0;
        end
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("m_valid_seen", m_valid, 1);
        check("m_result", m_result, exp);
        check("m_error", m_error, experr);
        check("lanes_held", (la_v === ea) && (lb_v === eb), 1);
        if (hold > 0) begin
            stable = 1'b1;
            r = m_result;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!m_valid || m_result !== r || la_v !== ea ||
                    lb_v !== eb || s_ready || !busy)
                    stable = 1'b0;
            end
            check("backpressure_hold", stable, 1);
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check("m_valid_drop", m_valid, 0);
        check("s_ready_after", s_ready, 1);
        check("busy_after", busy, 0);
        check("lanes_cleared", (la_v == '0) && (lb_v == '0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  stray;

        for (int i = 0; i < 6; i++) begin
            tbl[i].a    = '0;
            tbl[i].b    = '0;
            tbl[i].last = 1'b1;
        end
        tbl[0].n = 8;
        for (int j = 0; j < 8; j++) begin
            tbl[0].a[j] = 32'(j + 1);
            tbl[0].b[j] = 32'(j + 1);
        end
        tbl[0].exp = 204;
        tbl[1].n = 3;
        tbl[1].a[0] = 32'd2;
        tbl[1].b[0] = 32'd3;
        tbl[1].a[1] = 32'd4;
        tbl[1].b[1] = 32'd5;
        tbl[1].a[2] = 32'hffff_ffff;
        tbl[1].b[2] = 32'd7;
        tbl[1].exp = 19;
        tbl[2].n = 8;
        for (int j = 0; j < 8; j++) begin
            tbl[2].a[j] = 32'hffff_fff9;
            tbl[2].b[j] = 32'd3;
        end
        tbl[2].exp = -168;
        tbl[3].n = 1;
        tbl[3].a[0] = 32'd5;
        tbl[3].b[0] = 32'hffff_fffa;
        tbl[3].exp = -30;
        tbl[4].n = 8;
        tbl[4].last = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tbl[4].a[j] = 32'(1000 * (j + 1));
            tbl[4].b[j] = 32'd2;
        end
        tbl[4].exp = 72000;
        tbl[5].n = 1;
        tbl[5].a[0] = 32'h7fff_ffff;
        tbl[5].b[0] = 32'h7fff_ffff;
        tbl[5].exp = 64'h3fff_ffff_0000_0001;

        stuck   = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_acc_start", acc_start, 0);
        check("rst_m_result", m_result, 0);
        check("rst_m_error", m_error, 0);
        check("rst_lanes", (la_v == '0) && (lb_v == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_first_clk", s_ready, 1);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i], 1'b0);
            wait_result(tbl[i].exp, 1'b0, tbl[i], (i == 1) ? 20 : 0, lat);
            check("result_latency", 64'(lat), 64'd7);
        end

        // accelerator never answers
        stuck = 1'b1;
        send_frame(tbl[0], 1'b0);
        wait_result(0, 1'b1, tbl[0], 0, lat);
        check("timeout_latency", 64'(lat), 64'd17);
        stuck = 1'b0;
        send_frame(tbl[1], 1'b0);
        wait_result(tbl[1].exp, 1'b0, tbl[1], 0, lat);
        // done from the previous frame is still high here
        send_frame(tbl[0], 1'b0);
        wait_result(tbl[0].exp, 1'b0, tbl[0], 0, lat);

        // async reset while waiting for done
        send_frame(tbl[3], 1'b0);
        repeat (5) @(negedge clk);
        check("in_wait_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_acc_start", acc_start, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_m_result", m_result, 0);
        check("arst_m_error", m_error, 0);
        check("arst_lanes", (la_v == '0) && (lb_v == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (m_valid || acc_start) stray = 1'b1;
        end
        check("no_stray_after_reset", stray, 0);
        send_frame(tbl[0], 1'b0);
        wait_result(tbl[0].exp, 1'b0, tbl[0], 0, lat);

        // gapped input
        void'($urandom(42));
        send_frame(tbl[0], 1'b1);
        wait_result(tbl[0].exp, 1'b0, tbl[0], 0, lat);
        send_frame(tbl[2], 1'b1);
        wait_result(tbl[2].exp, 1'b0, tbl[2], 0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_feeder.md
Name: dot_product_feeder

Overview:
Upstream feeder and result collector for dot_product_accel. Accepts a stream of (a,b) operand pairs over a valid/ready handshake and packs them into the accelerator's eight operand lanes, zero-padding short frames. It issues the start pulse, tracks the done transition with a timeout, and returns the 64-bit result over a valid/ready output handshake. It sits between the bus/CSR stream logic and the accelerator.

Parameters:
LANES, 8, operand lanes; only 8 is supported (matches the accelerator).
WIDTH, 32, signed operand width.
TIMEOUT, 1024, maximum cycles from acc_start to done before the frame is aborted; must be ≥ 4.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
s_valid  input  1  operand pair valid
s_ready  output  1  feeder can accept a pair
s_a  input  WIDTH  signed operand a
s_b  input  WIDTH  signed operand b
s_last  input  1  final pair of the frame
a0..a7  output  WIDTH each  operand lanes to the accelerator
b0..b7  output  WIDTH each  operand lanes to the accelerator
acc_start  output  1  one-cycle start pulse to the accelerator
acc_done  input  1  accelerator done
acc_result  input  64  signed accelerator result
m_valid  output  1  result valid
m_ready  input  1  downstream accepts the result
m_result  output  64  signed result
m_error  output  1  frame aborted by timeout (m_result = 0)
busy  output  1  high in every state except LOAD

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - all lanes to 0, and acc_start, m_valid, m_error and busy to 0;
  - m_result to 0, the lane index to 0 and the timeout counter to 0.
  - State goes to LOAD and s_ready=1 on the first clk after release.
- Reset mid-operation discards the frame. No acc_start is issued afterwards for the old frame.
- LOAD:
  - s_ready=1. Each handshake (s_valid & s_ready) writes lane[idx]; idx then increments.
  - The frame ends on the handshake with s_last=1, or on the handshake at idx=7, whichever comes first. s_last at idx=7 is ordinary.
  - Lanes not written in the frame stay 0, because lanes are cleared when a result is accepted.
  - On the frame-end handshake: next state is START and idx resets to 0.
  - s_valid gaps are allowed; idx holds during gaps.
- START:
  - s_ready=0. acc_start=1 for exactly this one cycle (registered output).
  - Timeout counter cleared to 0. Next state is WAIT_CLR.
- WAIT_CLR:
  - Tolerates a stale done left high by the previous operation.
  - When acc_done=0, next state is WAIT_DONE. Minimum residency is one cycle.
- WAIT_DONE:
  - On acc_done=1, capture m_result=acc_result and m_error=0. Next state is OUTPUT.
- Timeout:
  - The counter increments every cycle in WAIT_CLR and WAIT_DONE.
  - When the counter = TIMEOUT-1 without a capture: m_result=0, m_error=1, next state is OUTPUT.
  - If done and timeout coincide in WAIT_DONE, done wins.
- Lane stability:
  - Lanes a0..a7/b0..b7 stay stable from START until the result is accepted.
  - Lanes are never modified while busy=1.
- OUTPUT:
  - m_valid=1. m_result and m_error hold stable until m_ready=1.
  - On handshake: m_valid drops next cycle, lanes are cleared to 0, and state returns to LOAD with s_ready=1 next cycle.
- Back-pressure: s_ready=0 in every state except LOAD. There is no double-buffering.
- Arithmetic: the feeder does none. Operands pass through unmodified as signed two's complement; the result is forwarded as 64-bit signed.
- Latency: acc_start asserts in the cycle after the frame-end handshake. m_valid asserts in the cycle after the capturing acc_done edge.

Test Plan:
1. Full frame, with the real dot_product_accel attached: pairs a=1..8, b=1..8 streamed back-to-back, s_last on the 8th → one acc_start pulse the cycle after the 8th handshake; m_valid with m_result=204, m_error=0.
2. Short frame: (2,3), (4,5), (-1,7) with s_last on the third pair → a3..a7 and b3..b7 = 0; m_result=19.
3. Back-pressure: hold m_ready=0 for 20 cycles after m_valid → m_valid, m_result and the lanes stay constant and s_ready=0 throughout; after the handshake, s_ready=1 next cycle and the lanes read 0.
4. Timeout: stub the accelerator with acc_done stuck at 0 and TIMEOUT=16 → m_valid rises 17 cycles after acc_start, with m_error=1 and m_result=0. Then a frame with stale done=1 against a normal model → the fresh done is captured correctly.
5. Reset mid-WAIT_DONE: assert rst_n=0 asynchronously → all outputs 0 without waiting for a clk edge, and there is no stray m_valid. Then rerun scenario 1 → 204.
6. Gapped input: rerun scenario 1 with s_valid randomly deasserted (seed 42) → m_result=204. Then negative operands a=-7, b=3 in all 8 lanes → m_result=-168.
